adder_arbiter: RTL

Round-robin arbiter and sequencer that shares one 32-bit add/subtract datapath (8-bit carry-lookahead chain with signed-overflow detect) between up to NREQ requesters. Requests are offered on a valid/ready handshake, and one is granted per cycle. Its operands feed the shared adder, and the result is captured in a single-entry response register tagged with the requester ID. It sits between the CPU-side units (ALU helpers, address generation, game-logic score/position updates) and the single adder instance, so that only one adder is built.

---
 rtl/adder_arbiter_if.sv | 28 ++
 rtl/adder_arbiter.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/adder_arbiter_if.sv
// Request/response bundle between the CPU-side requesters and the shared adder arbiter.
// Handshake: a beat moves when valid & ready are both high at a rising clock edge; the producer holds
// its payload stable while valid is high and ready is low, and ready never depends on a payload.
interface adder_arbiter_if #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
);
   logic [NREQ-1:0]      req_valid;
   logic [NREQ-1:0]      req_ready;
   logic [32*NREQ-1:0]   req_a;
   logic [32*NREQ-1:0]   req_b;
   logic [NREQ-1:0]      req_sub;
   logic                 rsp_valid;
   logic                 rsp_ready;
   logic [IDW-1:0]       rsp_id;
   logic [31:0]          rsp_sum;
   logic                 rsp_ovf;

   modport master (
      output req_valid, req_a, req_b, req_sub, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_ovf
   );

   modport slave (
      input  req_valid, req_a, req_b, req_sub, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_ovf
   );
endinterface

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one 32-bit carry-lookahead add/sub datapath with a one-entry tagged response slot.
// Optional feature macro ADDER_ARB_STICKY_OVF_EN adds per-requester sticky overflow flags (ovf_sticky/ovf_clear).
module adder_arbiter #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic            clock,
   input  logic            reset_n,
   adder_arbiter_if.slave  bus,
`ifdef ADDER_ARB_STICKY_OVF_EN
   input  logic [NREQ-1:0] ovf_clear,
   output logic [NREQ-1:0] ovf_sticky,
`endif
   output logic            state_dbg,
   output logic [IDW-1:0]  ptr_dbg
);

   localparam logic [0:0] ST_EMPTY = 1'b0;
   localparam logic [0:0] ST_FULL  = 1'b1;

   logic [0:0]      state_q;
   logic [IDW-1:0]  ptr_q;
   logic [IDW-1:0]  rsp_id_q;
   logic [31:0]     rsp_sum_q;
   logic            rsp_ovf_q;

   logic [NREQ-1:0] hi_mask;
   logic [NREQ-1:0] masked;
   logic [NREQ-1:0] grant;
   logic [IDW-1:0]  grant_id;
   logic            can_accept;
   logic            xfer;

   logic [31:0]     sel_a;
   logic [31:0]     sel_b;
   logic            sel_sub;
   logic [31:0]     eb;
   logic [31:0]     sum;
   logic            ovf;

   // Flattened 8-bit lookahead: every carry is a direct sum of generate/propagate products.
   function automatic logic [8:0] cla8(input logic [7:0] a, input logic [7:0] b, input logic cin);
      logic [7:0] g;
      logic [7:0] p;
      logic [8:0] c;
      logic       acc;
      logic       pp;
      g    = a & b;
      p    = a ^ b;
      c    = '0;
      c[0] = cin;
      for (int j = 0; j < 8; j++) begin
         acc = g[j];
         pp  = p[j];
         for (int k = j - 1; k >= 0; k--) begin
            acc = acc | (pp & g[k]);
            pp  = pp & p[k];
         end
         c[j+1] = acc | (pp & cin);
      end
      return {c[8], p ^ c[7:0]};
   endfunction

   // Search from ptr upward first; if nothing is valid there, wrap to the lowest valid index.
   always_comb begin
      hi_mask  = '0;
      grant    = '0;
      grant_id = '0;
      for (int i = 0; i < NREQ; i++) begin
         hi_mask[i] = (IDW'(i) >= ptr_q);
      end
      masked = bus.req_valid & hi_mask;
      if (|masked) begin
         for (int i = NREQ - 1; i >= 0; i--) begin
            if (masked[i]) grant_id = IDW'(i);
         end
      end else begin
         for (int i = NREQ - 1; i >= 0; i--) begin
            if (bus.req_valid[i]) grant_id = IDW'(i);
         end
      end
      for (int i = 0; i < NREQ; i++) begin
         grant[i] = (|bus.req_valid) && (grant_id == IDW'(i));
      end
   end

   assign can_accept    = (state_q == ST_EMPTY) || bus.rsp_ready;
   assign bus.req_ready = grant & {NREQ{can_accept & reset_n}};
   assign xfer          = |bus.req_ready;

   always_comb begin
      sel_a   = '0;
      sel_b   = '0;
      sel_sub = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant_id == IDW'(i)) begin
            sel_a   = bus.req_a[32*i +: 32];
            sel_b   = bus.req_b[32*i +: 32];
            sel_sub = bus.req_sub[i];
         end
      end
   end

   // Four lookahead blocks chained through their carry-outs; subtract is A + ~B + 1.
   always_comb begin
      logic       carry;
      logic [8:0] blk;
      eb    = sel_sub ? ~sel_b : sel_b;
      sum   = '0;
      carry = sel_sub;
      blk   = '0;
      for (int n = 0; n < 4; n++) begin
         blk            = cla8(sel_a[8*n +: 8], eb[8*n +: 8], carry);
         sum[8*n +: 8]  = blk[7:0];
         carry          = blk[8];
      end
      ovf = (sel_a[31] == eb[31]) && (sum[31] != sel_a[31]);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_EMPTY;
         ptr_q     <= '0;
         rsp_id_q  <= '0;
         rsp_sum_q <= '0;
         rsp_ovf_q <= 1'b0;
      end else begin
         case (state_q)
            ST_EMPTY: if (xfer) state_q <= ST_FULL;
            ST_FULL:  if (!xfer && bus.rsp_ready) state_q <= ST_EMPTY;
            default:  state_q <= ST_EMPTY;
         endcase
         if (xfer) begin
            ptr_q     <= (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);
            rsp_id_q  <= grant_id;
            rsp_sum_q <= sum;
            rsp_ovf_q <= ovf;
         end
      end
   end

`ifdef ADDER_ARB_STICKY_OVF_EN
   logic [NREQ-1:0] sticky_q;

   // Set term is ORed after the clear so an overflow in the clearing cycle survives.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sticky_q <= '0;
      end else begin
         sticky_q <= (sticky_q & ~ovf_clear) | (bus.req_ready & {NREQ{ovf}});
      end
   end

   assign ovf_sticky = sticky_q;
`endif

   assign bus.rsp_valid = (state_q == ST_FULL);
   assign bus.rsp_id    = rsp_id_q;
   assign bus.rsp_sum   = rsp_sum_q;
   assign bus.rsp_ovf   = rsp_ovf_q;
   assign state_dbg     = state_q;
   assign ptr_dbg       = ptr_q;

endmodule
